// File: rtl/button_input_conditioner_pkg.sv
// Shared button types: channel count, board bit positions and counter sizing.
// Pure declarations; no logic, no latency.
package ButtonTypes;

  localparam int unsigned NUM_BUTTONS = 4;

  localparam int unsigned BTN_C = 0;
  localparam int unsigned BTN_U = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_L = 3;

  typedef logic [NUM_BUTTONS-1:0] ButtonPath;

  // A one-cycle debounce still needs a 1-bit counter to keep the port legal.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/button_input_conditioner_if.sv
// Bundle between the board pins, the conditioner and the I/O controller.
// master = conditioner side (drives conditioned outputs); slave = consumer side.
interface button_input_conditioner_if #(
  parameter int unsigned NUM_BUTTONS = ButtonTypes::NUM_BUTTONS
);
  logic [NUM_BUTTONS-1:0] btnRaw;
  logic [NUM_BUTTONS-1:0] btnClear;
  logic [NUM_BUTTONS-1:0] btnLevel;
  logic [NUM_BUTTONS-1:0] btnPress;
  logic [NUM_BUTTONS-1:0] btnRelease;
  logic [NUM_BUTTONS-1:0] btnLatched;

  modport master (
    input  btnRaw, btnClear,
    output btnLevel, btnPress, btnRelease, btnLatched
  );

  modport slave (
    output btnRaw, btnClear,
    input  btnLevel, btnPress, btnRelease, btnLatched
  );
endinterface

// File: rtl/button_debounce_cell.sv
// One button channel: 2-flop sync, debounce counter, level, edge pulses, sticky latch.
// Level moves DEBOUNCE_CYCLES+2 edges after a stable raw change; clear acts next edge.
module button_debounce_cell
  import ButtonTypes::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clkBase,
  input  logic rst,
  input  logic btn_raw,
  input  logic btn_clear,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_latched
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             latched_q, latched_d;

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Any sample agreeing with the current level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    // A press on the same edge as a clear must not be lost.
    latched_d = (latched_q & ~btn_clear) | press_d;
  end

  always_ff @(posedge clkBase) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      latched_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      latched_q <= latched_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_latched = latched_q;

endmodule

// File: rtl/button_input_conditioner.sv
// Conditions NUM_BUTTONS raw push-buttons into level, press/release pulses and sticky flags.
// All outputs registered; NUM_BUTTONS must match the width of the attached interface.
module button_input_conditioner #(
  parameter int unsigned NUM_BUTTONS     = ButtonTypes::NUM_BUTTONS,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                         clkBase,
  input  logic                         rst,
  button_input_conditioner_if.master   btn
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clkBase     (clkBase),
      .rst         (rst),
      .btn_raw     (btn.btnRaw[i]),
      .btn_clear   (btn.btnClear[i]),
      .btn_level   (btn.btnLevel[i]),
      .btn_press   (btn.btnPress[i]),
      .btn_release (btn.btnRelease[i]),
      .btn_latched (btn.btnLatched[i])
    );
  end

endmodule

// File: tb/tb_button_input_conditioner.sv
// Directed bench for button_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_button_input_conditioner;
  import ButtonTypes::*;

  logic clkBase = 1'b0;
  logic rst     = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  button_input_conditioner_if #(.NUM_BUTTONS(NUM_BUTTONS)) bus ();

  button_input_conditioner #(
    .NUM_BUTTONS     (NUM_BUTTONS),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clkBase (clkBase),
    .rst     (rst),
    .btn     (bus.master)
  );

  always #5 clkBase = ~clkBase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input ButtonPath lvl, input ButtonPath prs,
                            input ButtonPath rel, input ButtonPath lat);
    check({tag, ".level"},   32'(bus.btnLevel),   32'(lvl));
    check({tag, ".press"},   32'(bus.btnPress),   32'(prs));
    check({tag, ".release"}, 32'(bus.btnRelease), 32'(rel));
    check({tag, ".latched"}, 32'(bus.btnLatched), 32'(lat));
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clkBase);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btnRaw   = '0;
    bus.btnClear = '0;
    tick(2);
    check_outs("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;

    // Clean press on C: level/pulse appear six edges after the raw change.
    bus.btnRaw[BTN_C] = 1'b1;
    tick(5);
    check_outs("press_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    check_outs("press_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    tick();
    check_outs("press_after", 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // Bounce on U: 1,0,0 then held 1; count restarts from the final rise.
    bus.btnRaw[BTN_U] = 1'b1;
    tick();
    bus.btnRaw[BTN_U] = 1'b0;
    tick(2);
    bus.btnRaw[BTN_U] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bounce_no_press", 32'(bus.btnPress), 32'h0);
    end
    check("bounce_level_wait", 32'(bus.btnLevel), 32'h1);
    tick();
    check_outs("bounce_edge", 4'b0011, 4'b0010, 4'b0000, 4'b0011);
    tick();
    check_outs("bounce_after", 4'b0011, 4'b0000, 4'b0000, 4'b0011);

    // Glitch on D of DEBOUNCE_CYCLES-1 samples: must be filtered.
    bus.btnRaw[BTN_D] = 1'b1;
    tick(3);
    bus.btnRaw[BTN_D] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("glitch_press", 32'(bus.btnPress), 32'h0);
    end
    check_outs("glitch_end", 4'b0011, 4'b0000, 4'b0000, 4'b0011);

    // Exactly DEBOUNCE_CYCLES samples on D: accepted, then released.
    bus.btnRaw[BTN_D] = 1'b1;
    tick(4);
    bus.btnRaw[BTN_D] = 1'b0;
    tick();
    check("min_pulse_wait", 32'(bus.btnLevel), 32'h3);
    tick();
    check_outs("min_pulse_press", 4'b0111, 4'b0100, 4'b0000, 4'b0111);
    tick(3);
    check_outs("min_pulse_hold", 4'b0111, 4'b0000, 4'b0000, 4'b0111);
    tick();
    check_outs("min_pulse_release", 4'b0011, 4'b0000, 4'b0100, 4'b0111);

    // Press then release on L, then clear its latch.
    bus.btnRaw[BTN_L] = 1'b1;
    tick(6);
    check_outs("l_press", 4'b1011, 4'b1000, 4'b0000, 4'b1111);
    bus.btnRaw[BTN_L] = 1'b0;
    tick(5);
    check_outs("l_release_wait", 4'b1011, 4'b0000, 4'b0000, 4'b1111);
    tick();
    check_outs("l_release", 4'b0011, 4'b0000, 4'b1000, 4'b1111);
    tick();
    check("l_release_after", 32'(bus.btnRelease), 32'h0);
    bus.btnClear = 4'b1000;
    tick();
    check_outs("l_clear", 4'b0011, 4'b0000, 4'b0000, 4'b0111);
    bus.btnClear = 4'b0000;
    tick();
    check("l_clear_hold", 32'(bus.btnLatched), 32'h7);

    // Release C, clear everything, and clear again while already empty.
    bus.btnRaw[BTN_C] = 1'b0;
    tick(6);
    check_outs("c_release", 4'b0010, 4'b0000, 4'b0001, 4'b0111);
    bus.btnClear = 4'b1111;
    tick();
    check("clear_all", 32'(bus.btnLatched), 32'h0);
    tick();
    check("clear_idle", 32'(bus.btnLatched), 32'h0);
    bus.btnClear = 4'b0000;

    // Clear held across the press edge: set wins, then the clear takes it.
    bus.btnRaw[BTN_C] = 1'b1;
    tick(5);
    bus.btnClear = 4'b0001;
    tick();
    check_outs("set_vs_clear", 4'b0011, 4'b0001, 4'b0000, 4'b0001);
    tick();
    check_outs("clear_after_set", 4'b0011, 4'b0000, 4'b0000, 4'b0000);
    bus.btnClear = 4'b0000;

    // Reset two edges into a count with all buttons held.
    bus.btnRaw = 4'b1111;
    tick(4);
    rst = 1'b1;
    tick();
    check_outs("mid_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    tick(5);
    check_outs("post_reset_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick();
    check_outs("post_reset_press", 4'b1111, 4'b1111, 4'b0000, 4'b1111);
    tick();
    check("post_reset_after", 32'(bus.btnPress), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
